inscache: RTL and testbench
===========================

INSCACHE -- requirements
Module: inscache

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 4, log2 of the number of direct-mapped one-word lines (16 lines).
REQ-002 SHALL have port clk_in  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-005 SHALL have port rob_clear  input  1  pipeline flush; aborts any outstanding miss.
REQ-006 SHALL have port ifetch_req  input  1  fetch unit requests the instruction at ifetch_addr this cycle.
REQ-007 SHALL have port ifetch_addr  input  32  instruction byte address; bits [1:0] ignored.
REQ-008 SHALL have port ins_valid  output  1  ins holds the instruction for ifetch_addr this cycle.
REQ-009 SHALL have port ins  output  32  instruction word.
REQ-010 SHALL have port is_fetch  output  1  registered; line-fill request to memory controller.
REQ-011 SHALL have port fetch_addr  output  32  registered; word-aligned fill address.
REQ-012 SHALL have port is_back  input  1  memory controller returns the fill word this cycle.
REQ-013 SHALL have port back_ins  input  32  fill word, valid only while is_back=1.

Function
REQ-014 SHALL split ifetch_addr as index=[INDEX_BITS+1:2], tag=[31:INDEX_BITS+2]; each line holds valid bit, tag, 32-bit word.
REQ-015 SHALL compute hit combinationally: ifetch_req && valid[index] && tag match; ins_valid=hit, ins=line word, same cycle, in any state.
REQ-016 SHALL drive ins=0 when ins_valid=0.
REQ-017 SHALL implement states IDLE and MISS.
REQ-018 IDLE, ifetch_req=1, no hit, rob_clear=0: next edge SHALL go MISS, set is_fetch=1, fetch_addr={ifetch_addr[31:2],2'b00}.
REQ-019 MISS: is_fetch and fetch_addr SHALL hold stable until the edge on which is_back=1 is sampled.
REQ-020 MISS, is_back=1, rob_clear=0: that edge SHALL write back_ins into line fetch_addr index, set valid, store tag, clear is_fetch, go IDLE.
REQ-021 is_fetch SHALL be 0 in the cycle after is_back=1, so the controller never starts a second fill for the same miss.
REQ-022 The filled word SHALL hit from the cycle after the fill edge; no same-cycle bypass of back_ins.
REQ-023 A new miss SHALL NOT be issued from MISS; non-hitting requests there get ins_valid=0 and are re-presented by the fetch unit.
REQ-024 rob_clear=1 in MISS SHALL clear is_fetch and go IDLE next edge without filling, even if is_back=1 that cycle (flush wins).
REQ-025 rob_clear=1 in IDLE SHALL suppress miss issue that cycle; valid bits and line contents SHALL never be cleared by rob_clear.
REQ-026 rdy_in=0 SHALL hold state, valid bits, lines, is_fetch, fetch_addr; is_back during rdy_in=0 SHALL be ignored.
REQ-027 A fill SHALL overwrite any previous line at that index (direct-mapped replacement).

Reset
REQ-028 rst_in=1 SHALL immediately force state IDLE, is_fetch=0, fetch_addr=0, all valid bits 0; line data/tags need not reset.
REQ-029 Reset asserted mid-MISS SHALL abandon the fill; a later is_back SHALL NOT write any line.
REQ-030 After reset release, first request to any address SHALL miss.

Verification
REQ-031 Cold miss: reset, ifetch_req=1 addr 0x0000_1004 -> next cycle is_fetch=1, fetch_addr=0x0000_1004; is_back with 0x0000_0513 -> is_fetch=0 next cycle; re-request -> ins_valid=1, ins=0x0000_0513.
REQ-032 Conflict: fill 0x0000_0010 then 0x0000_0050 (same index 4, INDEX_BITS=4) -> request 0x0000_0010 misses, fetch_addr=0x0000_0010.
REQ-033 Flush race: in MISS drive is_back=1 and rob_clear=1 together -> is_fetch=0 next cycle, line stays invalid, re-request misses.
REQ-034 Stall: in MISS hold rdy_in=0 five cycles with is_back pulses -> is_fetch, fetch_addr unchanged, no fill; fill completes after rdy_in=1.
REQ-035 Hit-under-miss: line 0x0000_0008 valid, in MISS for 0x0000_0020, request 0x0000_0008 -> ins_valid=1 same cycle, fetch_addr unchanged.
REQ-036 Async reset: assert rst_in between clock edges in MISS -> is_fetch=0 before next edge; later is_back writes nothing.

Source files
------------

// File: rtl/inscache.sv
// inscache: direct-mapped, one-word-per-line instruction cache.
//
// Lookup is combinational. A request that does not hit while the cache is
// idle starts a single-word fill from the memory controller. Requests that
// hit keep being served while a fill is outstanding.
//
// Ports
//   clk_in      sole clock, rising edge
//   rst_in      asynchronous active-high reset
//   rdy_in      global ready; low freezes all state
//   rob_clear   pipeline flush; aborts an outstanding miss
//   ifetch_req  fetch request for ifetch_addr this cycle
//   ifetch_addr instruction byte address (bits [1:0] ignored)
//   ins_valid   ins holds the instruction for ifetch_addr (hit)
//   ins         instruction word, 0 when ins_valid=0
//   is_fetch    registered fill request to the memory controller
//   fetch_addr  registered word-aligned fill address
//   is_back     memory controller returns the fill word this cycle
//   back_ins    fill word, valid while is_back=1
//
// State | meaning
// IDLE  | no fill outstanding; a non-hitting request starts one
// MISS  | fill outstanding; waits for is_back or rob_clear
module inscache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear,
    input  logic        ifetch_req,
    input  logic [31:0] ifetch_addr,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic        is_fetch,
    output logic [31:0] fetch_addr,
    input  logic        is_back,
    input  logic [31:0] back_ins
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state, state_n;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  hit;
    logic                  fill_en;
    logic                  is_fetch_n;
    logic [31:0]           fetch_addr_n;
    logic                  unused_addr_bits;

    assign req_idx  = ifetch_addr[INDEX_BITS+1:2];
    assign req_tag  = ifetch_addr[31:INDEX_BITS+2];
    assign fill_idx = fetch_addr[INDEX_BITS+1:2];

    // Byte-offset bits carry no information for word fetches.
    assign unused_addr_bits = ^{ifetch_addr[1:0], fetch_addr[1:0]};

    assign hit       = ifetch_req && valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign ins_valid = hit;
    assign ins       = hit ? data_mem[req_idx] : 32'h0;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            is_fetch   <= 1'b0;
            fetch_addr <= 32'h0;
        end else begin
            state      <= state_n;
            is_fetch   <= is_fetch_n;
            fetch_addr <= fetch_addr_n;
        end
    end

    // Everything is gated by rdy_in here, so a stall also drops any is_back.
    // In MISS the flush is tested first so it wins over a coincident is_back.
    always_comb begin
        state_n      = state;
        is_fetch_n   = is_fetch;
        fetch_addr_n = fetch_addr;
        fill_en      = 1'b0;
        if (rdy_in) begin
            case (state)
                IDLE: begin
                    if (ifetch_req && !hit && !rob_clear) begin
                        state_n      = MISS;
                        is_fetch_n   = 1'b1;
                        fetch_addr_n = {ifetch_addr[31:2], 2'b00};
                    end
                end
                MISS: begin
                    if (rob_clear) begin
                        state_n    = IDLE;
                        is_fetch_n = 1'b0;
                    end else if (is_back) begin
                        state_n    = IDLE;
                        is_fetch_n = 1'b0;
                        fill_en    = 1'b1;
                    end
                end
                default: begin
                    state_n    = IDLE;
                    is_fetch_n = 1'b0;
                end
            endcase
        end
    end

    // Valid bits are the only part of the array that needs a reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_en) begin
            data_mem[fill_idx] <= back_ins;
            tag_mem[fill_idx]  <= fetch_addr[31:INDEX_BITS+2];
        end
    end

endmodule

// File: tb/tb_inscache.sv
// tb_inscache: directed self-checking bench for inscache.
// Inputs change 1 ns after a rising edge; registered outputs are sampled
// there too, combinational outputs 1 ns after the inputs change.
module tb_inscache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        ifetch_req;
    logic [31:0] ifetch_addr;
    logic        ins_valid;
    logic [31:0] ins;
    logic        is_fetch;
    logic [31:0] fetch_addr;
    logic        is_back;
    logic [31:0] back_ins;

    int n_checks = 0;
    int n_errors = 0;

    inscache #(.INDEX_BITS(4)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .ifetch_req  (ifetch_req),
        .ifetch_addr (ifetch_addr),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .is_fetch    (is_fetch),
        .fetch_addr  (fetch_addr),
        .is_back     (is_back),
        .back_ins    (back_ins)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Present a request and check the combinational lookup result.
    task automatic lookup(input string tag, input logic [31:0] addr,
                          input logic exp_v, input logic [31:0] exp_ins);
        ifetch_req  = 1'b1;
        ifetch_addr = addr;
        #1;
        check({tag, "_valid"}, {31'h0, ins_valid}, {31'h0, exp_v});
        check({tag, "_ins"}, ins, exp_ins);
    endtask

    // Issue a miss for addr and complete it with data.
    task automatic fill(input string tag, input logic [31:0] addr, input logic [31:0] data);
        lookup({tag, "_miss"}, addr, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check({tag, "_is_fetch"}, {31'h0, is_fetch}, 32'h1);
        check({tag, "_fetch_addr"}, fetch_addr, {addr[31:2], 2'b00});
        is_back  = 1'b1;
        back_ins = data;
        step();
        is_back  = 1'b0;
        back_ins = 32'h0;
        check({tag, "_done"}, {31'h0, is_fetch}, 32'h0);
    endtask

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b1;
        rob_clear   = 1'b0;
        ifetch_req  = 1'b0;
        ifetch_addr = 32'h0;
        is_back     = 1'b0;
        back_ins    = 32'h0;
        step();
        step();
        check("rst_is_fetch", {31'h0, is_fetch}, 32'h0);
        check("rst_fetch_addr", fetch_addr, 32'h0);
        rst_in = 1'b0;
        step();

        // Cold miss, fetch address held while waiting.
        lookup("cold", 32'h0000_1004, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check("cold_is_fetch", {31'h0, is_fetch}, 32'h1);
        check("cold_fetch_addr", fetch_addr, 32'h0000_1004);
        step();
        check("cold_hold_fetch", {31'h0, is_fetch}, 32'h1);
        check("cold_hold_addr", fetch_addr, 32'h0000_1004);
        is_back  = 1'b1;
        back_ins = 32'h0000_0513;
        step();
        is_back  = 1'b0;
        back_ins = 32'h0;
        check("cold_fetch_cleared", {31'h0, is_fetch}, 32'h0);
        lookup("cold_hit", 32'h0000_1004, 1'b1, 32'h0000_0513);
        lookup("cold_hit_lowbits", 32'h0000_1006, 1'b1, 32'h0000_0513);
        ifetch_req = 1'b0;
        #1;
        check("no_req_ins", ins, 32'h0);

        // Conflict on index 4.
        fill("c10", 32'h0000_0010, 32'hAAAA_0010);
        lookup("c10_hit", 32'h0000_0010, 1'b1, 32'hAAAA_0010);
        fill("c50", 32'h0000_0050, 32'hBBBB_0050);
        lookup("c50_hit", 32'h0000_0050, 1'b1, 32'hBBBB_0050);
        lookup("c10_evicted", 32'h0000_0010, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check("c10_refetch", {31'h0, is_fetch}, 32'h1);
        check("c10_refetch_addr", fetch_addr, 32'h0000_0010);
        is_back  = 1'b1;
        back_ins = 32'hAAAA_0011;
        step();
        is_back = 1'b0;
        lookup("c10_refill", 32'h0000_0010, 1'b1, 32'hAAAA_0011);
        ifetch_req = 1'b0;

        // Flush race: rob_clear and is_back together.
        lookup("fr_miss", 32'h0000_0020, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check("fr_is_fetch", {31'h0, is_fetch}, 32'h1);
        is_back   = 1'b1;
        back_ins  = 32'hDEAD_0020;
        rob_clear = 1'b1;
        step();
        is_back   = 1'b0;
        rob_clear = 1'b0;
        check("fr_fetch_cleared", {31'h0, is_fetch}, 32'h0);
        lookup("fr_still_invalid", 32'h0000_0020, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check("fr_remiss", {31'h0, is_fetch}, 32'h1);
        check("fr_remiss_addr", fetch_addr, 32'h0000_0020);

        // Stall in MISS with is_back pulses.
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            is_back  = i[0] ? 1'b0 : 1'b1;
            back_ins = 32'hBAD0_0000 | i;
            step();
            check("stall_is_fetch", {31'h0, is_fetch}, 32'h1);
            check("stall_fetch_addr", fetch_addr, 32'h0000_0020);
        end
        is_back = 1'b0;
        lookup("stall_no_fill", 32'h0000_0020, 1'b0, 32'h0);
        ifetch_req = 1'b0;
        rdy_in   = 1'b1;
        is_back  = 1'b1;
        back_ins = 32'h2222_0020;
        step();
        is_back = 1'b0;
        check("stall_fill_done", {31'h0, is_fetch}, 32'h0);
        lookup("stall_hit", 32'h0000_0020, 1'b1, 32'h2222_0020);

        // rob_clear in IDLE suppresses issue but keeps lines.
        rob_clear = 1'b1;
        lookup("idle_clr_miss", 32'h0000_0030, 1'b0, 32'h0);
        step();
        check("idle_clr_no_fetch", {31'h0, is_fetch}, 32'h0);
        lookup("idle_clr_keeps", 32'h0000_0020, 1'b1, 32'h2222_0020);
        rob_clear  = 1'b0;
        ifetch_req = 1'b0;

        // Hit under miss.
        fill("hum8", 32'h0000_0008, 32'h0000_0088);
        lookup("hum_miss", 32'h0000_0024, 1'b0, 32'h0);
        step();
        check("hum_fetch_addr", fetch_addr, 32'h0000_0024);
        lookup("hum_hit", 32'h0000_0008, 1'b1, 32'h0000_0088);
        step();
        check("hum_addr_kept", fetch_addr, 32'h0000_0024);
        lookup("hum_other_miss", 32'h0000_0044, 1'b0, 32'h0);
        step();
        ifetch_req = 1'b0;
        check("hum_no_new_miss", fetch_addr, 32'h0000_0024);
        check("hum_still_fetch", {31'h0, is_fetch}, 32'h1);

        // Asynchronous reset between edges while in MISS.
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_is_fetch", {31'h0, is_fetch}, 32'h0);
        check("arst_fetch_addr", fetch_addr, 32'h0);
        #1;
        rst_in = 1'b0;
        step();
        is_back  = 1'b1;
        back_ins = 32'hDEAD_0024;
        step();
        is_back = 1'b0;
        check("arst_no_fetch", {31'h0, is_fetch}, 32'h0);
        lookup("arst_no_fill", 32'h0000_0024, 1'b0, 32'h0);
        lookup("arst_line0_cold", 32'h0000_0000, 1'b0, 32'h0);
        lookup("arst_cold", 32'h0000_0008, 1'b0, 32'h0);
        ifetch_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
